// File: rtl/algo_4ror1w_a3_req_sched_pkg.sv
// Shared definitions for the 4ror1w_a3 request scheduler.
//   NUMRPT        : number of client read lanes (and memory read ports)
//   A3_*          : default widths/depths of the algorithmic memory
//   wq_entry_t    : one write-queue entry {address, data}
package algo_4ror1w_a3_pkg;

    localparam int NUMRPT     = 4;
    localparam int A3_WIDTH   = 32;
    localparam int A3_BITWDTH = 5;
    localparam int A3_NUMADDR = 8192;
    localparam int A3_BITADDR = 13;

    typedef struct packed {
        logic [A3_BITADDR-1:0] adr;
        logic [A3_WIDTH-1:0]   dat;
    } wq_entry_t;

endpackage

// File: rtl/algo_4ror1w_a3_req_sched_if.sv
// Client-side request bus of the 4ror1w_a3 request scheduler.
//   cl_read   : per-lane read request             (client -> scheduler)
//   cl_rd_adr : read addresses, lane i at [i*BITADDR +: BITADDR]
//   cl_rd_rdy : all asserted read lanes accepted  (scheduler -> client)
//   cl_write  : write request                     (client -> scheduler)
//   cl_wr_adr : write address
//   cl_din    : write data
//   cl_wr_rdy : write accepted this cycle         (scheduler -> client)
// Modports: master = client side, slave = scheduler side.
interface algo_4ror1w_a3_req_sched_if
    import algo_4ror1w_a3_pkg::*;
#(
    parameter int WIDTH   = A3_WIDTH,
    parameter int BITADDR = A3_BITADDR
);

    logic [NUMRPT-1:0]         cl_read;
    logic [NUMRPT*BITADDR-1:0] cl_rd_adr;
    logic                      cl_rd_rdy;
    logic                      cl_write;
    logic [BITADDR-1:0]        cl_wr_adr;
    logic [WIDTH-1:0]          cl_din;
    logic                      cl_wr_rdy;

    modport master (
        output cl_read, cl_rd_adr, cl_write, cl_wr_adr, cl_din,
        input  cl_rd_rdy, cl_wr_rdy
    );

    modport slave (
        input  cl_read, cl_rd_adr, cl_write, cl_wr_adr, cl_din,
        output cl_rd_rdy, cl_wr_rdy
    );

endinterface

// File: rtl/algo_4ror1w_a3_req_sched_wqueue.sv
// Circular write FIFO for the request scheduler.
//   clk, rst     : clock, asynchronous active-low reset (clears pointers/count)
//   push         : enqueue push_entry at the edge
//   pop          : drop the head entry at the edge
//   head_entry   : oldest entry (meaningful only while cnt != 0)
//   cnt          : occupancy, 0..WQDEPTH
//   ent_vld      : per-slot valid flag, indexed by physical slot
//   ent_adr      : per-slot address, indexed by physical slot
// The slot-indexed valid/address view lets the scheduler compare every read
// lane against every live entry without walking the FIFO order.
module algo_4ror1w_a3_wqueue
    import algo_4ror1w_a3_pkg::*;
#(
    parameter int WQDEPTH = 4,
    parameter int BITWQ   = 2
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  wq_entry_t                           push_entry,
    input  logic                                pop,
    output wq_entry_t                           head_entry,
    output logic [BITWQ:0]                      cnt,
    output logic [WQDEPTH-1:0]                  ent_vld,
    output logic [WQDEPTH-1:0][A3_BITADDR-1:0]  ent_adr
);

    wq_entry_t        mem [WQDEPTH];
    logic [BITWQ-1:0] head;
    logic [BITWQ-1:0] tail;

    // pointers wrap naturally because WQDEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // storage carries no reset: occupancy alone decides what is live
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_entry;
    end

    assign head_entry = mem[head];

    // a slot is live when its distance from head is below the occupancy
    for (genvar i = 0; i < WQDEPTH; i++) begin : g_ent
        logic [BITWQ-1:0] offs;
        assign offs       = BITWQ'(i) - head;
        assign ent_vld[i] = ({1'b0, offs} < cnt);
        assign ent_adr[i] = mem[i].adr;
    end

endmodule

// File: rtl/algo_4ror1w_a3_req_sched.sv
// Request scheduler in front of the 4ror1w_a3 algorithmic memory.
// Each cycle it issues either up to four reads or exactly one write.
// Client writes are queued and drained on read-idle cycles, or forcibly when
// reads have starved the queue, the queue is full, or a pending read hits a
// queued write address.
//   clk, rst   : clock, asynchronous active-low reset
//   ready      : memory able to accept commands
//   cl         : client request bus (slave modport)
//   read       : registered read strobes to memory
//   rd_adr     : registered read addresses
//   write      : registered write strobe to memory
//   wr_adr     : registered write address
//   din        : registered write data
//   wq_cnt     : write-queue occupancy
module algo_4ror1w_a3_req_sched
    import algo_4ror1w_a3_pkg::*;
#(
    parameter int WIDTH     = A3_WIDTH,
    parameter int BITADDR   = A3_BITADDR,
    parameter int WQDEPTH   = 4,
    parameter int BITWQ     = 2,
    parameter int MAXSTARVE = 8,
    parameter int BITSTARVE = 4
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    algo_4ror1w_a3_req_sched_if.slave  cl,
    output logic [NUMRPT-1:0]          read,
    output logic [NUMRPT*BITADDR-1:0]  rd_adr,
    output logic                       write,
    output logic [BITADDR-1:0]         wr_adr,
    output logic [WIDTH-1:0]           din,
    output logic [BITWQ:0]             wq_cnt
);

    localparam logic [BITWQ:0]       WQ_FULL    = (BITWQ+1)'(WQDEPTH);
    localparam logic [BITSTARVE-1:0] STARVE_MAX = BITSTARVE'(MAXSTARVE);

    wq_entry_t                          push_entry;
    wq_entry_t                          head_entry;
    logic [WQDEPTH-1:0]                 ent_vld;
    logic [WQDEPTH-1:0][A3_BITADDR-1:0] ent_adr;
    logic [BITSTARVE-1:0]               starve_cnt;
    logic                               hazard;
    logic                               drain;
    logic                               push;
    logic                               rd_issue;

    assign push_entry = '{adr: cl.cl_wr_adr, dat: cl.cl_din};

    algo_4ror1w_a3_wqueue #(
        .WQDEPTH (WQDEPTH),
        .BITWQ   (BITWQ)
    ) u_wqueue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head_entry (head_entry),
        .cnt        (wq_cnt),
        .ent_vld    (ent_vld),
        .ent_adr    (ent_adr)
    );

    // read-after-write hazard: any requesting lane against any live entry
    always_comb begin
        hazard = 1'b0;
        for (int l = 0; l < NUMRPT; l++) begin
            for (int e = 0; e < WQDEPTH; e++) begin
                if (cl.cl_read[l] && ent_vld[e] &&
                    (cl.cl_rd_adr[l*BITADDR +: BITADDR] == ent_adr[e]))
                    hazard = 1'b1;
            end
        end
    end

    assign drain = ready && (wq_cnt != '0) &&
                   ((cl.cl_read == '0) || (starve_cnt == STARVE_MAX) ||
                    (wq_cnt == WQ_FULL) || hazard);

    // handshakes are held low while reset is asserted
    assign cl.cl_rd_rdy = rst && ready && !drain;
    assign cl.cl_wr_rdy = rst && ready && (wq_cnt < WQ_FULL);

    assign push     = cl.cl_write && cl.cl_wr_rdy;
    assign rd_issue = (cl.cl_read != '0) && cl.cl_rd_rdy;

    // command register stage: one write or a read group, never both.
    // Addresses/data hold their last value when the matching strobe is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read       <= '0;
            rd_adr     <= '0;
            write      <= 1'b0;
            wr_adr     <= '0;
            din        <= '0;
            starve_cnt <= '0;
        end else begin
            if (drain) begin
                write  <= 1'b1;
                wr_adr <= head_entry.adr;
                din    <= head_entry.dat;
                read   <= '0;
            end else if (rd_issue) begin
                read   <= cl.cl_read;
                rd_adr <= cl.cl_rd_adr;
                write  <= 1'b0;
            end else begin
                read   <= '0;
                write  <= 1'b0;
            end

            // counts read issues that bypass a non-empty queue
            if ((wq_cnt == '0) || drain)
                starve_cnt <= '0;
            else if (rd_issue && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_algo_4ror1w_a3_req_sched.sv
// Scoreboard bench for algo_4ror1w_a3_req_sched: directed scenarios followed
// by randomized traffic, checked against a queue-based reference model.
module tb_algo_4ror1w_a3_req_sched;

    localparam int WIDTH     = 32;
    localparam int BITADDR   = 13;
    localparam int WQDEPTH   = 4;
    localparam int BITWQ     = 2;
    localparam int MAXSTARVE = 8;

    typedef struct {
        logic [BITADDR-1:0] adr;
        logic [WIDTH-1:0]   dat;
    } ent_t;

    typedef struct {
        logic [3:0]           rd;
        logic [4*BITADDR-1:0] ra;
        logic                 wr;
        logic [BITADDR-1:0]   wa;
        logic [WIDTH-1:0]     wd;
        int                   cnt;
    } cmd_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ready;
    logic [3:0]           read;
    logic [4*BITADDR-1:0] rd_adr;
    logic                 write;
    logic [BITADDR-1:0]   wr_adr;
    logic [WIDTH-1:0]     din;
    logic [BITWQ:0]       wq_cnt;

    algo_4ror1w_a3_req_sched_if #(.WIDTH(WIDTH), .BITADDR(BITADDR)) sif ();

    algo_4ror1w_a3_req_sched #(
        .WIDTH(WIDTH), .BITADDR(BITADDR), .WQDEPTH(WQDEPTH), .BITWQ(BITWQ),
        .MAXSTARVE(MAXSTARVE), .BITSTARVE(4)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready), .cl(sif),
        .read(read), .rd_adr(rd_adr), .write(write), .wr_adr(wr_adr),
        .din(din), .wq_cnt(wq_cnt)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    ent_t mq[$];
    int   starve = 0;
    cmd_t exp_q[$];
    cmd_t mon_e;
    bit   last_wacc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    endtask

    function automatic logic [4*BITADDR-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [4*BITADDR-1:0] v;
        v = {BITADDR'(a3), BITADDR'(a2), BITADDR'(a1), BITADDR'(a0)};
        return v;
    endfunction

    // Drive one cycle of client inputs, predict the command the scheduler must
    // present after the next edge, and advance the reference model.
    task automatic step(input logic r, input logic rdy, input logic [3:0] rd,
                        input logic [4*BITADDR-1:0] ra, input logic w,
                        input logic [BITADDR-1:0] wa, input logic [WIDTH-1:0] wd);
        cmd_t e;
        bit   haz, drn, rrdy, wrdy;
        int   n;
        @(negedge clk);
        rst = r; ready = rdy;
        sif.cl_read = rd; sif.cl_rd_adr = ra;
        sif.cl_write = w; sif.cl_wr_adr = wa; sif.cl_din = wd;
        #1;
        if (!r) begin
            mq.delete();
            starve = 0;
        end
        n = mq.size();
        haz = 0;
        for (int l = 0; l < 4; l++)
            if (rd[l])
                for (int j = 0; j < n; j++)
                    if (mq[j].adr == ra[l*BITADDR +: BITADDR]) haz = 1;
        drn  = r && rdy && (n != 0) && (rd == 0 || starve == MAXSTARVE || n == WQDEPTH || haz);
        rrdy = r && rdy && !drn;
        wrdy = r && rdy && (n < WQDEPTH);
        chk("cl_rd_rdy", 64'(sif.cl_rd_rdy), 64'(rrdy));
        chk("cl_wr_rdy", 64'(sif.cl_wr_rdy), 64'(wrdy));
        chk("wq_cnt_pre", 64'(wq_cnt), 64'(n));
        e = '{rd: '0, ra: '0, wr: 1'b0, wa: '0, wd: '0, cnt: 0};
        if (drn) begin
            e.wr = 1'b1; e.wa = mq[0].adr; e.wd = mq[0].dat;
        end else if (rd != 0 && rrdy) begin
            e.rd = rd; e.ra = ra;
        end
        if (!r || n == 0 || drn) starve = 0;
        else if (e.rd != 0) starve = (starve < MAXSTARVE) ? starve + 1 : MAXSTARVE;
        if (drn) void'(mq.pop_front());
        last_wacc = w && wrdy;
        if (last_wacc) mq.push_back('{adr: wa, dat: wd});
        e.cnt = mq.size();
        exp_q.push_back(e);
    endtask

    // monitor: compares what the scheduler presents after each edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("read", 64'(read), 64'(mon_e.rd));
            chk("write", 64'(write), 64'(mon_e.wr));
            chk("wq_cnt", 64'(wq_cnt), 64'(mon_e.cnt));
            chk("rw_excl", 64'((read != 0) && write), 64'(0));
            if (mon_e.rd != 0) chk("rd_adr", 64'(rd_adr), 64'(mon_e.ra));
            if (mon_e.wr) begin
                chk("wr_adr", 64'(wr_adr), 64'(mon_e.wa));
                chk("din", 64'(din), 64'(mon_e.wd));
            end
        end
    end

    initial begin
        logic [4*BITADDR-1:0] busy;
        int i, guard;
        rst = 1'b0; ready = 1'b1;
        sif.cl_read = '0; sif.cl_rd_adr = '0; sif.cl_write = 1'b0;
        sif.cl_wr_adr = '0; sif.cl_din = '0;
        busy = pack4(0, 1, 2, 3);

        // reset state, then a full read group
        step(0, 1, 4'b1111, busy, 0, 0, 0);
        step(0, 1, 4'b1111, busy, 0, 0, 0);
        step(1, 1, 4'b1111, busy, 0, 0, 0);
        step(1, 1, 4'b0000, busy, 0, 0, 0);

        // single write with no reads drains right away
        step(1, 1, 4'b0000, busy, 1, 13'd5, 32'hA5A5A5A5);
        step(1, 1, 4'b0000, busy, 0, 0, 0);
        step(1, 1, 4'b0000, busy, 0, 0, 0);

        // starvation: one queued write under continuous reads
        step(1, 1, 4'b0001, busy, 1, 13'h100, 32'h11112222);
        for (int k = 0; k < 11; k++) step(1, 1, 4'b1111, busy, 0, 0, 0);
        step(1, 1, 4'b0000, busy, 0, 0, 0);

        // read-after-write hazard on lane 2
        step(1, 1, 4'b0001, busy, 1, 13'h10, 32'hDEADBEEF);
        step(1, 1, 4'b0100, pack4(0, 0, 16, 0), 0, 0, 0);
        step(1, 1, 4'b0100, pack4(0, 0, 16, 0), 0, 0, 0);
        step(1, 1, 4'b0000, busy, 0, 0, 0);

        // fill the queue while reads are busy; fifth write waits for a slot
        i = 0; guard = 0;
        while (i < 5 && guard < 20) begin
            step(1, 1, 4'b1111, busy, 1, BITADDR'(13'h200 + i), 32'h50000000 + i);
            if (last_wacc) i++;
            guard++;
        end
        chk("fill_accepts", 64'(i), 64'(5));
        for (int k = 0; k < 6; k++) step(1, 1, 4'b0000, busy, 0, 0, 0);

        // ready low holds the queue, then it drains
        step(1, 1, 4'b1111, busy, 1, 13'h300, 32'h30303030);
        step(1, 1, 4'b1111, busy, 1, 13'h301, 32'h31313131);
        for (int k = 0; k < 3; k++) step(1, 0, 4'b1111, busy, 1, 13'h302, 32'h32);
        for (int k = 0; k < 3; k++) step(1, 1, 4'b0000, busy, 0, 0, 0);

        // reset with three queued writes discards them
        for (int k = 0; k < 3; k++) step(1, 1, 4'b1111, busy, 1, BITADDR'(13'h400 + k), 32'h4000 + k);
        step(0, 1, 4'b0000, busy, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 4'b0000, busy, 0, 0, 0);

        // randomized traffic over a small address window to provoke hazards
        for (int k = 0; k < 2000; k++) begin
            logic [4*BITADDR-1:0] ra;
            logic [3:0] rd;
            ra = pack4($urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 15));
            rd = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0), rd, ra,
                 ($urandom_range(0, 2) == 0), BITADDR'($urandom_range(0, 15)), 32'($urandom));
        end

        step(1, 1, 4'b0000, busy, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
